// File: rtl/spram_gen2_pkg.sv
// spram_gen2_pkg: shared state encoding, lane width and lane parity helper for spram_gen2.
package spram_pkg;
  typedef enum logic [0:0] {S_CLEAR = 1'b0, S_READY = 1'b1} state_e;
  localparam int LANE_W = 8;
  function automatic logic lane_parity(input logic [LANE_W-1:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/spram_gen2_if.sv
// spram_gen2_if: access bus of spram_gen2 (active-low ENB/WEB/BWEB/OEB controls, read data and status).
interface spram_gen2_if #(parameter int AW = 8, parameter int DW = 8) ();
  localparam int LANES = DW / 8;
  logic             ENB;
  logic             WEB;
  logic [LANES-1:0] BWEB;
  logic [AW-1:0]    ADR;
  logic [DW-1:0]    D;
  logic             OEB;
  logic [DW-1:0]    Q;
  logic             QV;
  logic             RDY;
  logic             AERR;
  logic             PERR;
  modport master (output ENB, WEB, BWEB, ADR, D, OEB, input Q, QV, RDY, AERR, PERR);
  modport slave (input ENB, WEB, BWEB, ADR, D, OEB, output Q, QV, RDY, AERR, PERR);
endinterface

// File: rtl/spram_gen2_clr_seq.sv
// spram_clr_seq: post-reset clear sequencer; walks every address once, then raises RDY.
module spram_clr_seq
  import spram_pkg::*;
#(
  parameter int AW    = 8,
  parameter int DEPTH = 2 ** AW
) (
  input  logic          CLK,
  input  logic          RST,
  output logic [AW-1:0] clr_adr_o,
  output logic          clr_we_o,
  output logic          rdy_o
);
  localparam logic [0:0]    ST_CLR = S_CLEAR;
  localparam logic [0:0]    ST_RDY = S_READY;
  localparam logic [AW-1:0] LAST   = AW'(DEPTH - 1);
  logic [0:0]    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  always_comb begin
    state_d = (state_q == ST_CLR && cnt_q == LAST) ? ST_RDY : state_q;
    cnt_d   = (state_q == ST_CLR) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_CLR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  assign clr_adr_o = cnt_q;
  assign clr_we_o  = (state_q == ST_CLR);
  assign rdy_o     = (state_q == ST_RDY);
endmodule

// File: rtl/spram_gen2.sv
// spram_gen2: single-port RAM with byte-lane writes, optional output register and self-clear.
// Optional per-lane even parity storage and checking is enabled by defining SPRAM_PARITY_EN.
module spram_gen2
  import spram_pkg::*;
#(
  parameter int         AW      = 8,
  parameter int         DEPTH   = 2 ** AW,
  parameter int         DW      = 8,
  parameter int         OUT_REG = 0,
  parameter logic [7:0] CLR_VAL = 8'h00
) (
  input logic        CLK,
  input logic        RST,
  spram_gen2_if.slave bus
);
  localparam int LANES = DW / LANE_W;
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] clr_adr;
  logic          clr_we, rdy, acc, in_rng, rd, wr, perr_d;
  logic [DW-1:0] rdat_q, q_o;
  logic          qv_q, aerr_q, perr_q, qv_o, perr_o;
  spram_clr_seq #(.AW(AW), .DEPTH(DEPTH)) u_seq (
    .CLK       (CLK),
    .RST       (RST),
    .clr_adr_o (clr_adr),
    .clr_we_o  (clr_we),
    .rdy_o     (rdy)
  );
  assign acc    = rdy & ~bus.ENB;
  assign in_rng = 32'(bus.ADR) < 32'(DEPTH);
  assign rd     = acc & bus.WEB;
  assign wr     = acc & ~bus.WEB & in_rng;
  always_ff @(posedge CLK) begin
    if (clr_we) mem[clr_adr] <= {LANES{CLR_VAL}};
    else if (wr)
      for (int i = 0; i < LANES; i++)
        if (!bus.BWEB[i]) mem[bus.ADR][i*LANE_W +: LANE_W] <= bus.D[i*LANE_W +: LANE_W];
  end
`ifdef SPRAM_PARITY_EN
  logic [LANES-1:0] par [DEPTH];
  always_ff @(posedge CLK) begin
    if (clr_we) par[clr_adr] <= {LANES{lane_parity(CLR_VAL)}};
    else if (wr)
      for (int i = 0; i < LANES; i++)
        if (!bus.BWEB[i]) par[bus.ADR][i] <= lane_parity(bus.D[i*LANE_W +: LANE_W]);
  end
  always_comb begin
    perr_d = 1'b0;
    for (int i = 0; i < LANES; i++)
      perr_d = perr_d | (lane_parity(mem[bus.ADR][i*LANE_W +: LANE_W]) != par[bus.ADR][i]);
  end
`else
  assign perr_d = 1'b0;
`endif
  always_ff @(posedge CLK) begin
    if (RST) begin
      rdat_q <= '0;
      qv_q   <= 1'b0;
      aerr_q <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      qv_q   <= rd;
      aerr_q <= acc & ~in_rng;
      perr_q <= rd & in_rng & perr_d;
      if (rd) rdat_q <= in_rng ? mem[bus.ADR] : '0;
    end
  end
  if (OUT_REG != 0) begin : g_oreg
    logic [DW-1:0] q2_q;
    logic          qv2_q, perr2_q;
    always_ff @(posedge CLK) begin
      if (RST) begin
        q2_q    <= '0;
        qv2_q   <= 1'b0;
        perr2_q <= 1'b0;
      end else begin
        qv2_q   <= qv_q;
        perr2_q <= perr_q;
        if (qv_q) q2_q <= rdat_q;
      end
    end
    assign q_o    = q2_q;
    assign qv_o   = qv2_q;
    assign perr_o = perr2_q;
  end else begin : g_direct
    assign q_o    = rdat_q;
    assign qv_o   = qv_q;
    assign perr_o = perr_q;
  end
  assign bus.Q    = bus.OEB ? 'z : q_o;
  assign bus.QV   = qv_o;
  assign bus.RDY  = rdy;
  assign bus.AERR = aerr_q;
  assign bus.PERR = perr_o;
endmodule
